// File: rtl/imem_dmem_arbiter_if.sv
// CPU-side fetch/data ports and memory-side bus of the shared-memory arbiter.
// The arbiter takes the slave view; the CPU/memory environment takes the master view.
interface imem_dmem_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             if_req_i;
    logic [31:0]      if_addr_i;
    logic [31:0]      if_rdata_o;
    logic             if_ack_o;
    logic             if_stall_o;

    logic             dm_req_i;
    logic             dm_we_i;
    logic [31:0]      dm_addr_i;
    logic [31:0]      dm_wdata_i;
    logic [31:0]      dm_rdata_o;
    logic             dm_ack_o;
    logic             dm_stall_o;

    logic             mem_en_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic [31:0]      mem_rdata_i;

    logic [CNT_W-1:0] conflict_cnt_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o, if_stall_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output dm_rdata_o, dm_ack_o, dm_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output conflict_cnt_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o, if_stall_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  dm_rdata_o, dm_ack_o, dm_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  conflict_cnt_o
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between the IF and MEM-stage ports: one access
// at a time, fixed latency, one-cycle ack, alternating priority on conflicts.
module imem_dmem_arbiter #(
    parameter int unsigned MEM_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    imem_dmem_arbiter_if.slave   bus
);
    localparam int unsigned LAT_W = 4;
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_q, last_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [DW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             if_ack_q, if_ack_d;
    logic             dm_ack_q, dm_ack_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    dm_rdata_q, dm_rdata_d;
    logic             grant_dm_c, grant_if_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            lat_q       <= '0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lat_q       <= lat_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lat_d       = lat_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        // On a conflict the port that did not win last time gets the grant.
        grant_dm_c = bus.dm_req_i & (~bus.if_req_i | (last_q == OWN_IF));
        grant_if_c = bus.if_req_i & ~grant_dm_c;

        unique case (state_q)
            IDLE: begin
                if (grant_dm_c | grant_if_c) begin
                    state_d     = BUSY;
                    mem_en_d    = 1'b1;
                    lat_d       = LAT_W'(MEM_LAT - 1);
                    owner_d     = grant_dm_c ? OWN_DM : OWN_IF;
                    last_d      = grant_dm_c ? OWN_DM : OWN_IF;
                    mem_addr_d  = grant_dm_c ? bus.dm_addr_i : bus.if_addr_i;
                    mem_we_d    = grant_dm_c & bus.dm_we_i;
                    mem_wdata_d = bus.dm_wdata_i;
                    if (bus.if_req_i & bus.dm_req_i) begin
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWN_DM) begin
                        dm_ack_d = 1'b1;
                        if (!mem_we_q) dm_rdata_d = bus.mem_rdata_i;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata_i;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_en_o       = mem_en_q;
    assign bus.mem_we_o       = mem_we_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_wdata_o    = mem_wdata_q;
    assign bus.if_ack_o       = if_ack_q;
    assign bus.dm_ack_o       = dm_ack_q;
    assign bus.if_rdata_o     = if_rdata_q;
    assign bus.dm_rdata_o     = dm_rdata_q;
    assign bus.conflict_cnt_o = cnt_q;
    assign bus.if_stall_o     = bus.if_req_i & ~if_ack_q;
    assign bus.dm_stall_o     = bus.dm_req_i & ~dm_ack_q;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: a transaction-level timing model predicts
// strobes and acks; a monitor compares them. A second small-latency instance covers saturation.
module tb_imem_dmem_arbiter;
    localparam int unsigned LAT  = 3;
    localparam int unsigned CW   = 3;
    localparam int unsigned LATB = 1;
    localparam int unsigned CWB  = 2;
    localparam logic [31:0] BKEY = 32'h5A5A_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic rst_b;

    imem_dmem_arbiter_if #(.CNT_W(CW)) bus ();
    imem_dmem_arbiter #(.MEM_LAT(LAT), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    imem_dmem_arbiter_if #(.CNT_W(CWB)) bus_b ();
    imem_dmem_arbiter #(.MEM_LAT(LATB), .CNT_W(CWB)) dut_b (.clk_i(clk), .rst_i(rst_b), .bus(bus_b));
    assign bus_b.mem_rdata_i = bus_b.mem_addr_o ^ BKEY;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit b_done = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name, int act, int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // Memory device seen by the DUT
    logic [31:0] dev_mem [logic [31:0]];
    initial bus.mem_rdata_i = '0;
    always @(posedge clk) begin
        #1;
        if (bus.mem_en_o && bus.mem_we_o) dev_mem[bus.mem_addr_o] = bus.mem_wdata_o;
        bus.mem_rdata_i = dev_mem.exists(bus.mem_addr_o) ? dev_mem[bus.mem_addr_o]
                                                         : init_word(bus.mem_addr_o);
    end

    // Reference model: grant timestamps, alternation and a reference memory image
    typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } strobe_t;
    typedef struct { int cyc; logic [31:0] rdata; } ack_t;
    strobe_t     q_mem[$];
    ack_t        q_if[$];
    ack_t        q_dm[$];
    logic [31:0] ref_mem [logic [31:0]];
    int          m_next = 0;
    bit          m_last_dm = 1'b0;
    int          m_cnt = 0;
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_dm_rd = '0;
    bit          pick_dm;
    strobe_t     s_new;

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q_mem.delete(); q_if.delete(); q_dm.delete();
            m_next = cyc + 1; m_last_dm = 1'b0; m_cnt = 0;
            exp_if_rd = '0; exp_dm_rd = '0;
        end else if (cyc >= m_next && (bus.if_req_i || bus.dm_req_i)) begin
            pick_dm = bus.dm_req_i && (!bus.if_req_i || !m_last_dm);
            if (bus.if_req_i && bus.dm_req_i && m_cnt < (1 << CW) - 1) m_cnt++;
            m_last_dm = pick_dm;
            m_next = cyc + int'(LAT) + 2;
            if (pick_dm) begin
                s_new = '{cyc, bus.dm_addr_i, bus.dm_we_i, bus.dm_wdata_i};
                if (bus.dm_we_i) ref_mem[bus.dm_addr_i] = bus.dm_wdata_i;
                else exp_dm_rd = ref_read(bus.dm_addr_i);
                q_dm.push_back('{cyc + int'(LAT), exp_dm_rd});
            end else begin
                s_new = '{cyc, bus.if_addr_i, 1'b0, bus.dm_wdata_i};
                exp_if_rd = ref_read(bus.if_addr_i);
                q_if.push_back('{cyc + int'(LAT), exp_if_rd});
            end
            q_mem.push_back(s_new);
        end
    end

    // Monitor: pops expectations whenever the DUT strobes memory or acks a port
    strobe_t s_got;
    ack_t    a_got;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (bus.mem_en_o) begin
                if (q_mem.size() == 0) fail("unexpected_mem_en", cyc, -1);
                else begin
                    s_got = q_mem.pop_front();
                    check("grant_cycle", 32'(cyc), 32'(s_got.cyc));
                    check("mem_addr", bus.mem_addr_o, s_got.addr);
                    check("mem_we", 32'(bus.mem_we_o), 32'(s_got.we));
                    if (s_got.we) check("mem_wdata", bus.mem_wdata_o, s_got.wdata);
                    check("conflict_cnt", 32'(bus.conflict_cnt_o), 32'(m_cnt));
                end
            end else if (q_mem.size() != 0 && q_mem[0].cyc < cyc) begin
                fail("missing_mem_en", cyc, q_mem[0].cyc);
                void'(q_mem.pop_front());
            end
            if (bus.if_ack_o) begin
                if (q_if.size() == 0) fail("unexpected_if_ack", cyc, -1);
                else begin
                    a_got = q_if.pop_front();
                    check("if_ack_cycle", 32'(cyc), 32'(a_got.cyc));
                    check("if_rdata", bus.if_rdata_o, a_got.rdata);
                end
            end else if (q_if.size() != 0 && q_if[0].cyc < cyc) begin
                fail("missing_if_ack", cyc, q_if[0].cyc);
                void'(q_if.pop_front());
            end
            if (bus.dm_ack_o) begin
                if (q_dm.size() == 0) fail("unexpected_dm_ack", cyc, -1);
                else begin
                    a_got = q_dm.pop_front();
                    check("dm_ack_cycle", 32'(cyc), 32'(a_got.cyc));
                    check("dm_rdata", bus.dm_rdata_o, a_got.rdata);
                end
            end else if (q_dm.size() != 0 && q_dm[0].cyc < cyc) begin
                fail("missing_dm_ack", cyc, q_dm[0].cyc);
                void'(q_dm.pop_front());
            end
            check("if_stall", 32'(bus.if_stall_o), 32'(bus.if_req_i & ~bus.if_ack_o));
            check("dm_stall", 32'(bus.dm_stall_o), 32'(bus.dm_req_i & ~bus.dm_ack_o));
        end
    end

    task automatic serve(input int n_acks, input int budget);
        int got = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #2;
            if (bus.if_ack_o && bus.if_req_i) begin
                got++;
                if (n_acks == 0) bus.if_req_i = 1'b0;
            end
            if (bus.dm_ack_o && bus.dm_req_i) begin
                got++;
                if (n_acks == 0) bus.dm_req_i = 1'b0;
            end
            if (n_acks > 0 && got >= n_acks) begin
                bus.if_req_i = 1'b0;
                bus.dm_req_i = 1'b0;
            end
            if (!bus.if_req_i && !bus.dm_req_i) return;
        end
        fail("serve_timeout", got, n_acks);
        bus.if_req_i = 1'b0;
        bus.dm_req_i = 1'b0;
    endtask

    task automatic rand_step(input bit allow_new);
        @(posedge clk); #2;
        if (bus.if_req_i) begin
            if (bus.if_ack_o || $urandom_range(0, 31) == 0) bus.if_req_i = 1'b0;
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        end
        if (bus.dm_req_i) begin
            if (bus.dm_ack_o || $urandom_range(0, 31) == 0) bus.dm_req_i = 1'b0;
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            bus.dm_req_i   = 1'b1;
            bus.dm_we_i    = 1'($urandom_range(0, 1));
            bus.dm_addr_i  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            bus.dm_wdata_i = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dev_mem[32'h10] = 32'h8C01_0004;
        ref_mem[32'h10] = 32'h8C01_0004;
        rst = 1'b1;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h100; bus.dm_wdata_i = '0;

        // Reset held with both requests high
        repeat (2) begin
            @(posedge clk); #2;
            check("rst_mem_en", 32'(bus.mem_en_o), 0);
            check("rst_mem_we", 32'(bus.mem_we_o), 0);
            check("rst_mem_addr", bus.mem_addr_o, 0);
            check("rst_mem_wdata", bus.mem_wdata_o, 0);
            check("rst_if_ack", 32'(bus.if_ack_o), 0);
            check("rst_dm_ack", 32'(bus.dm_ack_o), 0);
            check("rst_if_rdata", bus.if_rdata_o, 0);
            check("rst_dm_rdata", bus.dm_rdata_o, 0);
            check("rst_conflict", 32'(bus.conflict_cnt_o), 0);
        end
        rst = 1'b0;
        serve(0, 40);

        // IF fetch alone
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h10;
        serve(0, 40);

        // Continuous dual requests, DM write
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h40; bus.dm_wdata_i = 32'hDEAD_BEEF;
        serve(4, 60);

        // Reset in the middle of a DM read
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h100;
        for (int k = 0; k < 20 && !bus.mem_en_o; k++) begin
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        rst = 1'b1; bus.dm_req_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        check("rst_mid_dm_ack", 32'(bus.dm_ack_o), 0);
        check("rst_mid_mem_en", 32'(bus.mem_en_o), 0);
        repeat (6) rand_step(1'b0);
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h104;
        serve(0, 40);

        // Random traffic, then drain
        repeat (600) rand_step(1'b1);
        for (int k = 0; k < 100; k++) begin
            if (!bus.if_req_i && !bus.dm_req_i && q_if.size() == 0 && q_dm.size() == 0) break;
            rand_step(1'b0);
        end
        repeat (4) @(posedge clk);
        for (int k = 0; k < 200 && !b_done; k++) @(posedge clk);
        if (!b_done) fail("b_timeout", 0, 1);
        if (q_mem.size() != 0) fail("leftover_strobes", q_mem.size(), 0);
        if (q_if.size() != 0) fail("leftover_if_acks", q_if.size(), 0);
        if (q_dm.size() != 0) fail("leftover_dm_acks", q_dm.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // One-cycle latency instance: continuous dual requests, alternation and saturation
    initial begin
        int gcyc = -1;
        int ngr = 0;
        int bc = 0;
        logic [31:0] if_a = '0;
        rst_b = 1'b1;
        bus_b.if_req_i = 1'b1; bus_b.if_addr_i = '0;
        bus_b.dm_req_i = 1'b1; bus_b.dm_we_i = 1'b0; bus_b.dm_addr_i = 32'h200; bus_b.dm_wdata_i = '0;
        repeat (2) @(posedge clk);
        #2 rst_b = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            bc++;
            if (bus_b.mem_en_o) begin
                if (gcyc >= 0) check("b_grant_period", 32'(bc - gcyc), 3);
                check("b_grant_owner", 32'(bus_b.mem_addr_o == 32'h200), 32'(ngr % 2 == 0));
                gcyc = bc;
                ngr++;
            end
            if (bus_b.if_ack_o) begin
                check("b_if_ack_lat", 32'(bc - gcyc), 1);
                check("b_if_rdata", bus_b.if_rdata_o, if_a ^ BKEY);
                #1;
                if_a = if_a + 32'h4;
                bus_b.if_addr_i = if_a;
            end
            if (bus_b.dm_ack_o) begin
                check("b_dm_ack_lat", 32'(bc - gcyc), 1);
                check("b_dm_rdata", bus_b.dm_rdata_o, 32'h200 ^ BKEY);
            end
        end
        check("b_grant_count", 32'(ngr), 6);
        check("b_conflict_sat", 32'(bus_b.conflict_cnt_o), 3);
        b_done = 1'b1;
    end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Sequencer that shares one single-port unified memory between the pipelined CPU's instruction-fetch (IF) port and data-memory (MEM-stage) port.
- Grants one access at a time and drives the memory for a fixed, parameterised latency.
- Returns read data with a one-cycle ack pulse.
- Drives per-port stall outputs that the CPU uses to gate PC/IF_ID writes and to freeze the MEM stage.

Parameters:
MEM_LAT, 3, memory access latency in cycles. Read data is valid MEM_LAT edges after the grant edge. Legal range 1..15.
CNT_W, 16, width of the saturating conflict counter.

Ports:
clk_i  input  1  clock; all state updates on posedge
rst_i  input  1  synchronous, active-high reset
if_req_i  input  1  fetch request; held with if_addr_i until if_ack_o
if_addr_i  input  32  fetch address
if_rdata_o  output  32  fetched instruction; holds until the next IF ack
if_ack_o  output  1  one-cycle pulse: fetch complete
if_stall_o  output  1  if_req_i & ~if_ack_o (combinational)
dm_req_i  input  1  data request; held with addr/we/wdata until dm_ack_o
dm_we_i  input  1  1 = write, 0 = read
dm_addr_i  input  32  data address
dm_wdata_i  input  32  write data
dm_rdata_o  output  32  read data; holds until the next DM read ack
dm_ack_o  output  1  one-cycle pulse: data access complete
dm_stall_o  output  1  dm_req_i & ~dm_ack_o (combinational)
mem_en_o  output  1  one-cycle access strobe to memory
mem_we_o  output  1  write enable; valid with mem_en_o
mem_addr_o  output  32  address; stable from grant until return to IDLE
mem_wdata_o  output  32  write data; stable like mem_addr_o
mem_rdata_i  input  32  memory read data; sampled at the completing edge
conflict_cnt_o  output  CNT_W  grants made while both requests were pending; saturating

Behaviour:
- Clock/reset: one clock (clk_i). Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE, cnt=0, owner=IF, last_owner=IF. All outputs 0: mem_*_o, *_ack_o, *_rdata_o, conflict_cnt_o.
- Reset mid-access: the access is abandoned, no ack is issued, mem_en_o=0. The next request after reset is granted normally.
- States: IDLE, BUSY, RESP.
- IDLE, no request: remain in IDLE; mem_en_o=0.
- IDLE, exactly one request pending: grant it.
- IDLE, both requests pending: grant the port not equal to last_owner. After reset, DM therefore wins the first conflict. conflict_cnt_o increments, saturating at all-ones.
- On the grant edge:
  - latch addr, we (IF forces we=0) and wdata into mem_addr_o, mem_we_o, mem_wdata_o;
  - mem_en_o<=1; owner<=granted port; last_owner<=granted port;
  - cnt<=MEM_LAT-1; state<=BUSY.
- BUSY: mem_en_o<=0 after its first cycle, so it is high for exactly one cycle. mem_addr_o, mem_we_o and mem_wdata_o are held.
  - If cnt==0: state<=RESP, owner's ack<=1. On a read, owner's rdata<=mem_rdata_i.
  - Else: cnt<=cnt-1.
- RESP: the ack is high for this single cycle. Next edge: ack<=0, state<=IDLE.
- Timing: ack is visible after grant edge + MEM_LAT. The next grant is possible at grant edge + MEM_LAT + 2. Back-to-back service period is MEM_LAT+2 cycles.
- Write access: dm_ack_o pulses; dm_rdata_o is unchanged.
- Requests are sampled only in IDLE. A request dropped during BUSY still completes, and its ack still pulses; the requester ignores it.
- The non-granted port sees its stall held high until its own ack.
- Alternation on continuous dual requests guarantees neither port waits more than 2×(MEM_LAT+2) cycles from request to grant.

Test Plan:
- Reset: hold rst_i 2 cycles with both reqs high -> all outputs 0, no mem_en_o. Release -> DM granted first.
- IF read alone, MEM_LAT=3, if_addr_i=0x10, model returns 0x8C010004:
  - mem_en_o high exactly 1 cycle after grant edge 0, with mem_addr_o=0x10 and mem_we_o=0;
  - if_ack_o pulses once after edge 3 with if_rdata_o=0x8C010004;
  - if_stall_o high edges 0–2, low with the ack.
- Simultaneous DM read 0x100 and IF 0x20 from IDLE after reset:
  - DM ack after edge 3; IF granted at edge 5, IF ack after edge 8;
  - conflict_cnt_o=1; dm_stall_o and if_stall_o behave per their definitions.
- Both reqs held continuously for 4 grants, DM write 0xDEADBEEF to 0x40 -> grant order DM, IF, DM, IF:
  - mem_we_o=1 only on DM grants; dm_rdata_o unchanged; conflict_cnt_o=4.
- rst_i pulsed at edge 2 of a DM read -> no dm_ack_o, state IDLE. A re-issued read 0x104 completes with correct data 3 edges after its grant.
- MEM_LAT=1, IF requests back-to-back at 0x0, 0x4, 0x8 -> each ack 1 edge after its grant, grants 3 edges apart. Force CNT_W=2 with 5 conflicts -> conflict_cnt_o saturates at 3.
